// File: rtl/fifo_memory_pkg.sv
// rtl/fifo_memory_pkg.sv - shared defaults and fill-count type for the programmable FIFO
package fifo_memory_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 4;

  typedef logic [DEF_ADDR_WIDTH:0] fill_count_t;

endpackage

// File: rtl/fifo_memory_ram.sv
// rtl/fifo_memory_ram.sv - simple dual-port FIFO storage; FIFO_MEMORY_PROG_FWFT_EN selects combinational read
module fifo_memory_ram
  import fifo_memory_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
`ifndef FIFO_MEMORY_PROG_FWFT_EN
  input  logic                  reset,
  input  logic                  re,
`endif
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

`ifdef FIFO_MEMORY_PROG_FWFT_EN
  assign rdata = mem[raddr];
`else
  // Output register only; the array itself carries no reset.
  always_ff @(posedge clk) begin
    if (reset) rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end
`endif

endmodule

// File: rtl/fifo_memory_prog.sv
// rtl/fifo_memory_prog.sv - FIFO with programmable almost-flags and sticky errors; FIFO_MEMORY_PROG_FWFT_EN selects FWFT
module fifo_memory_prog
  import fifo_memory_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  write,
  input  logic                  read,
  input  logic [ADDR_WIDTH:0]   afull_thr,
  input  logic [ADDR_WIDTH:0]   aempty_thr,
  input  logic                  clr_err,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  empty,
  output logic                  full,
  output logic                  ale,
  output logic                  alf,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  ovf,
  output logic                  udf
);

  localparam int                    DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   FULL_CNT = DEPTH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = CNT_ONE[ADDR_WIDTH-1:0];

  logic [ADDR_WIDTH-1:0] wptr;
  logic [ADDR_WIDTH-1:0] rptr;
  logic [ADDR_WIDTH:0]   cnt_q;
  logic                  push;
  logic                  pop;
  logic                  ovf_q;
  logic                  udf_q;

  assign count = cnt_q;
  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == FULL_CNT);
  assign ale   = (cnt_q <= aempty_thr);
  assign alf   = (cnt_q >= afull_thr);
  assign ovf   = ovf_q;
  assign udf   = udf_q;

  // A pop frees a slot for a same-cycle push at full; a push never legalises a pop on empty.
  assign pop  = read & ~empty & ~reset;
  assign push = write & (~full | pop) & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (push) wptr <= wptr + PTR_ONE;
      if (pop)  rptr <= rptr + PTR_ONE;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CNT_ONE;
        2'b01:   cnt_q <= cnt_q - CNT_ONE;
        default: cnt_q <= cnt_q;
      endcase
      // New error beats a same-cycle clear.
      ovf_q <= (write & ~push) | (ovf_q & ~clr_err);
      udf_q <= (read & ~pop) | (udf_q & ~clr_err);
    end
  end

  fifo_memory_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk  (clk),
`ifndef FIFO_MEMORY_PROG_FWFT_EN
    .reset(reset),
    .re   (pop),
`endif
    .we   (push),
    .waddr(wptr),
    .wdata(din),
    .raddr(rptr),
    .rdata(dout)
  );

endmodule

// File: doc/fifo_memory_prog.md
FIFO_MEMORY_PROG -- requirements
Module: fifo_memory_prog

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, word width in bits.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 4; depth DEPTH = 2**ADDR_WIDTH words.
REQ-003 The block SHALL have one clock and a synchronous active-high reset; ports SHALL be as follows:
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 din  input  DATA_WIDTH  write data.
REQ-007 write  input  1  push request.
REQ-008 read  input  1  pop request.
REQ-009 afull_thr  input  ADDR_WIDTH+1  almost-full threshold, sampled every cycle.
REQ-010 aempty_thr  input  ADDR_WIDTH+1  almost-empty threshold, sampled every cycle.
REQ-011 clr_err  input  1  clears sticky error flags.
REQ-012 dout  output  DATA_WIDTH  read data.
REQ-013 empty / full  output  1 each  count==0 / count==DEPTH.
REQ-014 ale / alf  output  1 each  almost-empty / almost-full.
REQ-015 count  output  ADDR_WIDTH+1  current fill level, 0..DEPTH.
REQ-016 ovf / udf  output  1 each  sticky overflow / underflow.

Function
REQ-017 Push accepted when write=1 and (full=0 or read accepted in the same cycle); din stored at the write pointer.
REQ-018 Pop accepted when read=1 and empty=0; a simultaneous write does not make a read on empty legal.
REQ-019 Pointers SHALL be ADDR_WIDTH bits, wrap DEPTH-1 -> 0, and advance only on accepted push/pop.
REQ-020 count: +1 on push only, -1 on pop only, unchanged on both or neither; registered.
REQ-021 empty, full, ale, alf SHALL be combinational from registered count and current thresholds.
REQ-022 ale = (count <= aempty_thr); alf = (count >= afull_thr); threshold values above DEPTH are legal and compare unsigned.
REQ-023 Standard mode: dout SHALL present the popped word one cycle after the accepted pop and hold it otherwise.
REQ-024 write=1 while full with no accepted pop SHALL be dropped and set ovf; read=1 while empty SHALL be ignored and set udf.
REQ-025 ovf/udf SHALL stay set until clr_err=1; a new error in the same cycle as clr_err SHALL win (flag stays 1).
REQ-026 Storage contents SHALL never be corrupted by a dropped write.

Reset
REQ-027 On reset=1 at a clk edge: pointers=0, count=0, dout=0, ovf=0, udf=0; empty=1, full=0 follow.
REQ-028 Reset mid-operation SHALL discard all stored words; push/pop in the reset cycle SHALL be ignored.
REQ-029 Storage array SHALL NOT require reset.

Configuration
REQ-030 Macro FIFO_MEMORY_PROG_FWFT_EN SHALL select first-word-fall-through mode.
REQ-031 With the macro defined: dout SHALL show the head word whenever empty=0 (zero read latency); an accepted pop advances to the next word in the same cycle; dout is don't-care while empty.
REQ-032 Without the macro: standard one-cycle read latency per REQ-023; count/flags identical in both modes.

Structure
REQ-033 Package fifo_memory_pkg SHALL hold default DATA_WIDTH/ADDR_WIDTH constants and a typedef for the fill-count type.
REQ-034 Storage SHALL be sub-module fifo_memory_ram: simple dual-port, one synchronous write port, one read port (registered or combinational per mode).
REQ-035 Pointer, count, flag and error logic SHALL reside in fifo_memory_prog.

Verification
REQ-036 Fill: reset, 16 writes 0x00..0x0F (defaults) -> count=16, full=1, alf=1 with afull_thr=14 from count 14; 16 reads -> 0x00..0x0F in order, empty=1.
REQ-037 Overflow: full, write=1 read=0 with din=0xAA -> ovf=1, count=16, later reads never return 0xAA; clr_err -> ovf=0.
REQ-038 Underflow: empty, read=1 write=1 din=0x55 -> udf=1, count=1, next read returns 0x55.
REQ-039 Simultaneous push/pop at full and at count=5 -> count unchanged, order preserved across pointer wrap (>=40 ops).
REQ-040 Thresholds: aempty_thr=3, afull_thr=17 -> ale=1 for count 0..3, alf never asserts; change thresholds live -> flags update same cycle.
REQ-041 Reset at count=9 mid-burst -> next cycle count=0, empty=1, ovf=udf=0; run both with and without FIFO_MEMORY_PROG_FWFT_EN checking dout latency 0 vs 1.
